// File: rtl/timer_arbiter.sv
// Shared interval timer: round-robin arbitration of four delay requests onto
// one prescaler and one down-counter, with tick enables and done pulses.
//   state | meaning
//   IDLE  | no delay running; arbitrate pending requests
//   RUN   | prescaler counting, remaining decremented on each wrap
//   DONE  | one-cycle done pulse on channel last
module timer_arbiter #(
  parameter int PRESCALE = 80_000,
  parameter int DW       = 16
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] delay_in,
  input  logic [3:0]      cancel,
  output logic [3:0]      grant,
  output logic [3:0]      done,
  output logic            busy,
  output logic            tick,
  output logic [DW-1:0]   remaining
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      last;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            win_vld;
  logic [PW-1:0]   pre;
  logic            wrap;
  logic            cancel_hit;
  logic            expire;

  // Lowest offset from last+1 wins; offset 4 (last itself) has lowest priority.
  always_comb begin
    win     = last;
    win_vld = 1'b0;
    idx     = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  assign wrap       = (pre == PW'(PRESCALE - 1));
  assign cancel_hit = |(cancel & grant);
  assign expire     = (remaining == '0) || (wrap && (remaining == DW'(1)));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (win_vld) state_nxt = S_RUN;
      S_RUN: begin
        if (cancel_hit)  state_nxt = S_IDLE;
        else if (expire) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    tick = (state == S_RUN) && wrap;
    done = (state == S_DONE) ? (4'b0001 << last) : 4'b0000;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      last      <= 2'd3;
      pre       <= '0;
      remaining <= '0;
      grant     <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            grant     <= 4'b0001 << win;
            last      <= win;
            remaining <= delay_in[win*DW +: DW];
            pre       <= '0;
          end
        end
        S_RUN: begin
          // Cancel beats expiry; either way the channel is released with no count left.
          if (cancel_hit || expire) begin
            grant     <= 4'b0000;
            remaining <= '0;
            pre       <= '0;
          end else if (wrap) begin
            pre       <= '0;
            remaining <= remaining - DW'(1);
          end else begin
            pre <= pre + PW'(1);
          end
        end
        default: begin
          grant     <= 4'b0000;
          remaining <= '0;
          pre       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: expected grant/tick/done events are queued
// by the stimulus and popped by a monitor as the DUT presents them.
module tb_timer_arbiter;

  localparam int PRESCALE = 4;
  localparam int DW       = 8;

  localparam int K_GRANT = 0;
  localparam int K_TICK  = 1;
  localparam int K_DONE  = 2;

  logic            clk_in;
  logic            reset;
  logic [3:0]      req;
  logic [4*DW-1:0] delay_in;
  logic [3:0]      cancel;
  logic [3:0]      grant;
  logic [3:0]      done;
  logic            busy;
  logic            tick;
  logic [DW-1:0]   remaining;

  timer_arbiter #(.PRESCALE(PRESCALE), .DW(DW)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .req       (req),
    .delay_in  (delay_in),
    .cancel    (cancel),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .tick      (tick),
    .remaining (remaining)
  );

  typedef struct {
    int          kind;
    logic [3:0]  val;
    logic [7:0]  rem;
    int          dt;   // cycles since previous event; 0 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input int kind, input logic [3:0] val, input logic [7:0] rem, input int dt);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.rem  = rem;
    e.dt   = dt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input bit is_done, input logic [3:0] val, input int maxc, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < maxc && !hit; i++) begin
      @(negedge clk_in);
      if ((is_done ? done : grant) == val) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: timed out after %0d cycles waiting for %b", name, maxc, val);
    end
  endtask

  // Monitor: one event per cycle at most (grant rise, tick and done are mutually exclusive).
  int         cyc = 0;
  int         last_ev_cyc = 0;
  int         ev_num = 0;
  logic [3:0] prev_grant = 4'b0000;
  always @(negedge clk_in) begin
    ev_t obs;
    ev_t e;
    bit  seen;
    cyc++;
    seen     = 1'b0;
    obs.kind = 0;
    obs.val  = 4'b0000;
    obs.rem  = remaining;
    obs.dt   = cyc - last_ev_cyc;
    if (grant != 4'b0000 && grant != prev_grant) begin
      obs.kind = K_GRANT; obs.val = grant; seen = 1'b1;
    end else if (tick) begin
      obs.kind = K_TICK; obs.val = grant; seen = 1'b1;
    end else if (done != 4'b0000) begin
      obs.kind = K_DONE; obs.val = done; seen = 1'b1;
    end
    prev_grant = grant;
    if (seen) begin
      ev_num++;
      checks++;
      last_ev_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event%0d: got kind=%0d val=%b rem=%0d with nothing expected",
                 ev_num, obs.kind, obs.val, obs.rem);
      end else begin
        e = exp_q.pop_front();
        if (obs.kind != e.kind || obs.val != e.val || obs.rem != e.rem ||
            (e.dt != 0 && obs.dt != e.dt)) begin
          errors++;
          $display("FAIL event%0d: got kind=%0d val=%b rem=%0d dt=%0d expected kind=%0d val=%b rem=%0d dt=%0d",
                   ev_num, obs.kind, obs.val, obs.rem, obs.dt, e.kind, e.val, e.rem, e.dt);
        end
      end
    end
  end

  logic [3:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    cancel   = 4'b0000;
    delay_in = '0;
    repeat (2) @(negedge clk_in);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_remaining", 32'(remaining), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);

    // Round-robin from last=3: 0,1,2,3,0 each delay 1, grants 6 cycles apart.
    for (int i = 0; i < 5; i++) begin
      push(K_GRANT, rr_seq[i], 8'd1, (i == 0) ? 0 : 2);
      push(K_TICK,  rr_seq[i], 8'd1, 3);
      push(K_DONE,  rr_seq[i], 8'd0, 1);
    end
    delay_in = {8'd1, 8'd1, 8'd1, 8'd1};
    req      = 4'b1111;
    for (int i = 0; i < 4; i++) wait_for(1'b1, rr_seq[i], 20, "rr_done");
    wait_for(1'b0, 4'b0001, 10, "rr_wrap_grant");
    req = 4'b0000;
    wait_for(1'b1, 4'b0001, 20, "rr_last_done");
    repeat (3) @(negedge clk_in);

    // Single request, delay 3: ticks at cycles 4,8,12, done at 13, idle at 14.
    push(K_GRANT, 4'b0001, 8'd3, 0);
    push(K_TICK,  4'b0001, 8'd3, 3);
    push(K_TICK,  4'b0001, 8'd2, 4);
    push(K_TICK,  4'b0001, 8'd1, 4);
    push(K_DONE,  4'b0001, 8'd0, 1);
    delay_in = {8'd9, 8'd9, 8'd9, 8'd3};
    req      = 4'b0001;
    wait_for(1'b1, 4'b0001, 30, "single_done");
    req = 4'b0000;
    @(negedge clk_in);
    chk("single_busy_after", 32'(busy), 32'h0);
    chk("single_done_len", 32'(done), 32'h0);
    repeat (2) @(negedge clk_in);

    // Zero delay on channel 2: done right after the grant cycle, no tick.
    push(K_GRANT, 4'b0100, 8'd0, 0);
    push(K_DONE,  4'b0100, 8'd0, 1);
    delay_in = {8'd9, 8'd0, 8'd9, 8'd9};
    req      = 4'b0100;
    wait_for(1'b1, 4'b0100, 10, "zero_done");
    req = 4'b0000;
    repeat (3) @(negedge clk_in);

    // Cancel: channel 1 delay 5; foreign cancel ignored, own cancel at cycle 7.
    push(K_GRANT, 4'b0010, 8'd5, 0);
    push(K_TICK,  4'b0010, 8'd5, 3);
    delay_in = {8'd9, 8'd9, 8'd5, 8'd9};
    req      = 4'b0010;
    wait_for(1'b0, 4'b0010, 10, "cancel_grant");
    @(negedge clk_in);
    cancel = 4'b0001;
    @(negedge clk_in);
    cancel = 4'b0000;
    chk("cancel_foreign_grant", 32'(grant), 32'h2);
    repeat (4) @(negedge clk_in);
    chk("cancel_rem_before", 32'(remaining), 32'd4);
    cancel = 4'b0010;
    req    = 4'b0000;
    @(negedge clk_in);
    cancel = 4'b0000;
    chk("cancel_grant_cleared", 32'(grant), 32'h0);
    chk("cancel_remaining", 32'(remaining), 32'h0);
    chk("cancel_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk_in);

    // Cancel on the expiry edge of channel 2; channel 3 served next.
    push(K_GRANT, 4'b0100, 8'd1, 0);
    push(K_TICK,  4'b0100, 8'd1, 3);
    push(K_GRANT, 4'b1000, 8'd2, 2);
    push(K_TICK,  4'b1000, 8'd2, 3);
    push(K_TICK,  4'b1000, 8'd1, 4);
    push(K_DONE,  4'b1000, 8'd0, 1);
    delay_in = {8'd2, 8'd1, 8'd9, 8'd9};
    req      = 4'b1100;
    wait_for(1'b0, 4'b0100, 10, "final_grant");
    repeat (3) @(negedge clk_in);
    chk("final_tick_cycle", 32'(tick), 32'h1);
    cancel = 4'b0100;
    req    = 4'b1000;
    @(negedge clk_in);
    cancel = 4'b0000;
    chk("final_no_done", 32'(done), 32'h0);
    chk("final_grant_cleared", 32'(grant), 32'h0);
    wait_for(1'b1, 4'b1000, 20, "final_next_done");
    req = 4'b0000;
    repeat (3) @(negedge clk_in);

    // Reset mid-run, then channel 3 granted on the first edge after release.
    push(K_GRANT, 4'b0001, 8'd5, 0);
    push(K_TICK,  4'b0001, 8'd5, 3);
    push(K_GRANT, 4'b1000, 8'd1, 0);
    push(K_TICK,  4'b1000, 8'd1, 3);
    push(K_DONE,  4'b1000, 8'd0, 1);
    delay_in = {8'd1, 8'd9, 8'd9, 8'd5};
    req      = 4'b0001;
    wait_for(1'b0, 4'b0001, 10, "rst_first_grant");
    repeat (5) @(negedge clk_in);
    reset = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_remaining", 32'(remaining), 32'h0);
    req = 4'b1000;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    @(posedge clk_in);
    #1;
    chk("rst_release_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    wait_for(1'b1, 4'b1000, 20, "rst_done");
    repeat (10) @(negedge clk_in);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
